// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt sequencer: state encoding, cause codes and
// default register-file save addresses.
package int_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ARMED      = 3'd1;
  localparam state_t ST_SAVE_PC    = 3'd2;
  localparam state_t ST_SAVE_CAUSE = 3'd3;
  localparam state_t ST_VECTOR     = 3'd4;
  localparam state_t ST_KERNEL     = 3'd5;
  localparam state_t ST_RETURN     = 3'd6;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE  = 2'd0;
  localparam cause_t CAUSE_SYS   = 2'd1;
  localparam cause_t CAUSE_TIMER = 2'd2;
  localparam cause_t CAUSE_OP    = 2'd3;

  localparam logic [7:0] DEFAULT_EPC_ADDR   = 8'd30;
  localparam logic [7:0] DEFAULT_CAUSE_ADDR = 8'd31;

  // Fixed priority: syscall > timer > DMA op.
  function automatic cause_t pick_cause(input logic sys_req, input logic timer_req,
                                        input logic op_req);
    if (sys_req)        return CAUSE_SYS;
    else if (timer_req) return CAUSE_TIMER;
    else if (op_req)    return CAUSE_OP;
    else                return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/int_priority_sel.sv
// Combinational interrupt winner selection and vector lookup.
// win_cause comes from the live requests; vector is selected by the caller's cause_sel.
module int_priority_sel
  import int_seq_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                sys_req,
  input  logic                timer_req,
  input  logic                op_req,
  input  cause_t              cause_sel,
  input  logic [PC_WIDTH-1:0] sys_vec,
  input  logic [PC_WIDTH-1:0] timer_vec,
  input  logic [PC_WIDTH-1:0] op_vec,
  output cause_t              win_cause,
  output logic [PC_WIDTH-1:0] vector
);

  always_comb begin
    win_cause = pick_cause(sys_req, timer_req, op_req);
  end

  always_comb begin
    vector = '0;
    unique case (cause_sel)
      CAUSE_SYS:   vector = sys_vec;
      CAUSE_TIMER: vector = timer_vec;
      CAUSE_OP:    vector = op_vec;
      default:     vector = '0;
    endcase
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: saves EPC and cause, vectors, tracks kernel mode.
// Optional INT_SEQ_STATS_EN adds a wrapping 16-bit int_count of taken interrupts.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int         PC_WIDTH   = 16,
  parameter logic [7:0] EPC_ADDR   = DEFAULT_EPC_ADDR,
  parameter logic [7:0] CAUSE_ADDR = DEFAULT_CAUSE_ADDR
) (
  input  logic                clock,
  input  logic                init_flag,
  input  logic                timer_int,
  input  logic                op_int,
  input  logic [PC_WIDTH-1:0] int_pos,
  input  logic [PC_WIDTH-1:0] op_int_pos,
  input  logic [PC_WIDTH-1:0] sys_int_pos,
  input  logic                SYS_call,
  input  logic                RTI_flag,
  input  logic                PRG_ENB,
  input  logic [PC_WIDTH-1:0] PC_pos,
  output logic                stall,
  output logic                PC_load,
  output logic [PC_WIDTH-1:0] PC_load_value,
  output logic                kernel_mode,
  output logic                timer_ack,
  output logic                RF_write_flag,
  output logic [7:0]          RF_write_addr,
  output logic [31:0]         RF_write_data
`ifdef INT_SEQ_STATS_EN
  ,
  output logic [15:0]         int_count
`endif
);

  state_t              state_q, state_d;
  logic                sys_pend_q, sys_pend_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  cause_t              cause_q, cause_d;
  cause_t              win_cause;
  logic [PC_WIDTH-1:0] sel_vector;
  logic                pending;

  int_priority_sel #(
    .PC_WIDTH (PC_WIDTH)
  ) u_sel (
    .sys_req   (sys_pend_q),
    .timer_req (timer_int),
    .op_req    (op_int),
    .cause_sel (cause_q),
    .sys_vec   (sys_int_pos),
    .timer_vec (int_pos),
    .op_vec    (op_int_pos),
    .win_cause (win_cause),
    .vector    (sel_vector)
  );

  assign pending = sys_pend_q | timer_int | op_int;

  always_comb begin
    state_d    = state_q;
    sys_pend_d = sys_pend_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    // Syscalls only latch outside the entry/kernel window, so they never nest.
    if (SYS_call && (state_q == ST_IDLE || state_q == ST_ARMED)) sys_pend_d = 1'b1;
    case (state_q)
      ST_IDLE: if (pending) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!pending) begin
          state_d = ST_IDLE;
        end else if (PRG_ENB) begin
          epc_d   = PC_pos;
          cause_d = win_cause;
          state_d = ST_SAVE_PC;
        end
      end
      ST_SAVE_PC:    state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE: state_d = ST_VECTOR;
      ST_VECTOR: begin
        if (cause_q == CAUSE_SYS) sys_pend_d = 1'b0;
        state_d = ST_KERNEL;
      end
      ST_KERNEL: if (RTI_flag) state_d = ST_RETURN;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      state_q    <= ST_IDLE;
      sys_pend_q <= 1'b0;
      epc_q      <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      sys_pend_q <= sys_pend_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    stall         = 1'b0;
    PC_load       = 1'b0;
    PC_load_value = '0;
    kernel_mode   = 1'b0;
    timer_ack     = 1'b0;
    RF_write_flag = 1'b0;
    RF_write_addr = 8'd0;
    RF_write_data = 32'd0;
    case (state_q)
      ST_SAVE_PC: begin
        stall         = 1'b1;
        RF_write_flag = 1'b1;
        RF_write_addr = EPC_ADDR;
        RF_write_data = 32'(epc_q);
      end
      ST_SAVE_CAUSE: begin
        stall         = 1'b1;
        RF_write_flag = 1'b1;
        RF_write_addr = CAUSE_ADDR;
        RF_write_data = 32'(cause_q);
      end
      ST_VECTOR: begin
        PC_load       = 1'b1;
        PC_load_value = sel_vector;
        kernel_mode   = 1'b1;
        timer_ack     = (cause_q == CAUSE_TIMER);
      end
      ST_KERNEL: kernel_mode = 1'b1;
      ST_RETURN: begin
        PC_load       = 1'b1;
        PC_load_value = epc_q;
      end
      default: ;
    endcase
  end

`ifdef INT_SEQ_STATS_EN
  logic [15:0] int_count_q;

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      int_count_q <= 16'd0;
    end else if (state_q == ST_VECTOR) begin
      int_count_q <= int_count_q + 16'd1;
    end
  end

  assign int_count = int_count_q;
`endif

endmodule
